// File: rtl/keypad_pkg.sv
// Shared encodings for the 4x4 keypad scanner: FSM states, idle row pattern, column strobe decode.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_t;

    localparam logic [3:0] ROW_IDLE  = 4'hF;
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Active-low one-cold strobe for a column index.
    function automatic logic [3:0] col_decode(input logic [1:0] idx);
        col_decode = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/row_prio_enc.sv
// Active-low row priority encoder: lowest low row wins; any is set when some row is low.
module row_prio_enc
    import keypad_pkg::*;
(
    input  logic [3:0] row,
    output logic [1:0] idx,
    output logic       any
);

    always_comb begin
        idx = 2'd0;
        any = (row != ROW_IDLE);
        if (!row[0])      idx = 2'd0;
        else if (!row[1]) idx = 2'd1;
        else if (!row[2]) idx = 2'd2;
        else if (!row[3]) idx = 2'd3;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with tick-paced column rotation and press/release debounce.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   SCAN      | rotate the low column strobe each tick until a row goes low
//   DEB_PRESS | column frozen; count ticks with the row matching the capture
//   HELD      | key accepted; wait for all rows released
//   DEB_REL   | count released ticks before returning to SCAN
module keypad_scanner #(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned CNT_W          = 4,
    parameter int unsigned REPEAT_DELAY   = 12,
    parameter int unsigned REPEAT_PERIOD  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    import keypad_pkg::*;

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam bit PARAMS_OK = (DEBOUNCE_TICKS >= 1) && (DEBOUNCE_TICKS <= CNT_MAX)
                            && (REPEAT_DELAY >= 1) && (REPEAT_DELAY <= CNT_MAX)
                            && (REPEAT_PERIOD >= 1) && (REPEAT_PERIOD <= CNT_MAX);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("keypad_scanner: counter parameters out of range for CNT_W");
        end
    endgenerate

    // Terminal value: the tick that sees this count is the DEBOUNCE_TICKS-th match.
    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_TICKS - 1);

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DELAY_LD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] REP_PERIOD_LD = CNT_W'(REPEAT_PERIOD);
    logic [CNT_W-1:0] rep_cnt;
`endif

    kp_state_t        state;
    logic [1:0]       col_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       row_cap;
    logic [1:0]       row_idx_cap;
    logic [1:0]       row_idx;
    logic             row_any;

    row_prio_enc u_row_prio_enc (
        .row (row),
        .idx (row_idx),
        .any (row_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            col         <= COL_RESET;
            cnt         <= '0;
            row_cap     <= ROW_IDLE;
            row_idx_cap <= 2'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (row_any) begin
                            row_cap     <= row;
                            row_idx_cap <= row_idx;
                            cnt         <= '0;
                            state       <= DEB_PRESS;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col     <= col_decode(col_idx + 2'd1);
                        end
                    end
                    DEB_PRESS: begin
                        if (row == row_cap) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == DEB_TERM) begin
                                key_code  <= {row_idx_cap, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= REP_DELAY_LD;
`endif
                            end
                        end else begin
                            cnt   <= '0;
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!row_any) begin
                            cnt   <= '0;
                            state <= DEB_REL;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= '0;
                        end else if (rep_cnt == 1) begin
                            key_valid <= 1'b1;
                            rep_cnt   <= REP_PERIOD_LD;
                        end else begin
                            rep_cnt <= rep_cnt - 1'b1;
`endif
                        end
                    end
                    DEB_REL: begin
                        if (!row_any) begin
                            cnt <= cnt + 1'b1;
                            if (cnt == DEB_TERM) begin
                                key_held <= 1'b0;
                                col_idx  <= col_idx + 2'd1;
                                col      <= col_decode(col_idx + 2'd1);
                                state    <= SCAN;
                            end
                        end else begin
                            // Release bounce: back to HELD without a new key_valid.
                            cnt   <= '0;
                            state <= HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= REP_DELAY_LD;
`endif
                        end
                    end
                endcase
            end
        end
    end

endmodule
